// File: rtl/optical_bit_sampler.sv
// Oversampling receiver for the optical link: finds the start bit on the synchronized
// photodiode line, samples each data bit mid-cell and strobes out good bytes.
module optical_bit_sampler #(
    parameter int unsigned OVERSAMPLE = 4,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_clk,
    input  logic                 light_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] CellLast = TickW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic                 sc_q;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic                 tick;

    // sample_clk is produced in this clock domain, so an edge detect is enough.
    assign tick = sample_clk & ~sc_q;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (rx_s_q) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                    end
                end
                StStart: begin
                    // Re-check the start bit at its midpoint to reject glitches.
                    if (tick_cnt_q == HalfLast) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rx_s_q ? StData : StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StData: begin
                    if (tick_cnt_q == CellLast) begin
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_idx_q == IdxLast) begin
                            state_d = StStop;
                        end else begin
                            bit_idx_d = bit_idx_q + IdxW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StStop: begin
                    if (tick_cnt_q == CellLast) begin
                        tick_cnt_d = '0;
                        if (!rx_s_q) begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                            state_d      = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StWaitIdle;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                StWaitIdle: begin
                    if (!rx_s_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            rx_meta_q    <= 1'b0;
            rx_s_q       <= 1'b0;
            sc_q         <= 1'b0;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= light_in;
            rx_s_q       <= rx_meta_q;
            sc_q         <= sample_clk;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_optical_bit_sampler.sv
// Directed bench for optical_bit_sampler: drives tick-aligned frames and checks strobes,
// captured bytes and busy against hand-computed values.
module tb_optical_bit_sampler;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       sample_clk = 1'b0;
    logic       light_in   = 1'b0;
    logic       sc_en      = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int total  = 0;
    int bad    = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;

    optical_bit_sampler #(
        .OVERSAMPLE(4),
        .DATA_BITS (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sample_clk(sample_clk),
        .light_in  (light_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Sample clock toggles every 6 system clocks; forced low when disabled.
    initial begin
        forever begin
            repeat (6) @(posedge clock);
            #1;
            if (sc_en) sample_clk = ~sample_clk;
            else       sample_clk = 1'b0;
        end
    end

    // Strobe counters, sampled on the falling edge.
    always @(negedge clock) begin
        if (data_valid) n_valid++;
        if (frame_err) n_err++;
        if (data_valid && frame_err) n_both++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick_wait(input int n);
        repeat (n) @(posedge sample_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        light_in = 1'b1;
        tick_wait(4);
        for (int i = 0; i < 8; i++) begin
            light_in = b[i];
            tick_wait(4);
        end
        light_in = stop_bit;
        tick_wait(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", data_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b0;
        tick_wait(4);
    endtask

    task automatic test_good_frame();
        int bv = n_valid;
        int be = n_err;
        tick_wait(1);
        send_frame(8'hA5, 1'b0);
        light_in = 1'b0;
        total++; if (n_valid !== bv + 1) begin bad++; $display("FAIL a5_valid_count got=%0d want=%0d", n_valid, bv + 1); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", data_out); end
        total++; if (n_err !== be) begin bad++; $display("FAIL a5_err_count got=%0d want=%0d", n_err, be); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy_after got=%b want=0", busy); end
        tick_wait(4);
    endtask

    task automatic test_false_start();
        int bv = n_valid;
        int be = n_err;
        tick_wait(1);
        light_in = 1'b1;
        tick_wait(1);
        light_in = 1'b0;
        tick_wait(1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL false_start_busy got=%b want=1", busy); end
        tick_wait(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL false_start_idle got=%b want=0", busy); end
        total++; if (n_valid !== bv) begin bad++; $display("FAIL false_start_valid got=%0d want=%0d", n_valid, bv); end
        total++; if (n_err !== be) begin bad++; $display("FAIL false_start_err got=%0d want=%0d", n_err, be); end
    endtask

    task automatic test_frame_error();
        int bv = n_valid;
        int be = n_err;
        tick_wait(1);
        send_frame(8'h5A, 1'b1);
        repeat (200) @(posedge clock);
        #1;
        total++; if (n_err !== be + 1) begin bad++; $display("FAIL ferr_count got=%0d want=%0d", n_err, be + 1); end
        total++; if (n_valid !== bv) begin bad++; $display("FAIL ferr_valid got=%0d want=%0d", n_valid, bv); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL ferr_data_hold got=%h want=a5", data_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_stuck got=%b want=1", busy); end
        light_in = 1'b0;
        tick_wait(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        int bv = n_valid;
        tick_wait(1);
        send_frame(8'h00, 1'b0);
        total++; if (n_valid !== bv + 1) begin bad++; $display("FAIL b2b_first_count got=%0d want=%0d", n_valid, bv + 1); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL b2b_first_data got=%h want=00", data_out); end
        send_frame(8'hFF, 1'b0);
        light_in = 1'b0;
        total++; if (n_valid !== bv + 2) begin bad++; $display("FAIL b2b_second_count got=%0d want=%0d", n_valid, bv + 2); end
        total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL b2b_second_data got=%h want=ff", data_out); end
        tick_wait(4);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'h3C;
        int bv = n_valid;
        tick_wait(1);
        light_in = 1'b1;
        tick_wait(4);
        for (int i = 0; i < 4; i++) begin
            light_in = b[i];
            tick_wait(4);
        end
        light_in = b[4];
        tick_wait(2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        light_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h want=00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", data_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b want=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        reset = 1'b0;
        tick_wait(6);
        total++; if (n_valid !== bv) begin bad++; $display("FAIL mid_abort_valid got=%0d want=%0d", n_valid, bv); end
        send_frame(8'h3C, 1'b0);
        light_in = 1'b0;
        total++; if (n_valid !== bv + 1) begin bad++; $display("FAIL fresh_3c_count got=%0d want=%0d", n_valid, bv + 1); end
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL fresh_3c_data got=%h want=3c", data_out); end
        tick_wait(4);
    endtask

    task automatic test_no_tick();
        int bv = n_valid;
        int be = n_err;
        logic [7:0] d0 = data_out;
        tick_wait(1);
        sc_en = 1'b0;
        repeat (20) @(posedge clock);
        for (int i = 0; i < 20; i++) begin
            light_in = ~light_in;
            repeat (7) @(posedge clock);
        end
        light_in = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL notick_idle_busy got=%b want=0", busy); end
        total++; if (data_out !== d0) begin bad++; $display("FAIL notick_idle_data got=%h want=%h", data_out, d0); end
        total++; if (n_valid !== bv || n_err !== be) begin
            bad++; $display("FAIL notick_idle_strobes got=%0d/%0d want=%0d/%0d", n_valid, n_err, bv, be);
        end
        sc_en = 1'b1;
        tick_wait(1);
        light_in = 1'b1;
        tick_wait(6);
        sc_en = 1'b0;
        repeat (10) @(posedge clock);
        for (int i = 0; i < 20; i++) begin
            light_in = ~light_in;
            repeat (7) @(posedge clock);
        end
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL notick_frame_busy got=%b want=1", busy); end
        total++; if (data_out !== d0) begin bad++; $display("FAIL notick_frame_data got=%h want=%h", data_out, d0); end
        total++; if (n_valid !== bv || n_err !== be) begin
            bad++; $display("FAIL notick_frame_strobes got=%0d/%0d want=%0d/%0d", n_valid, n_err, bv, be);
        end
        light_in = 1'b0;
        sc_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_no_tick();
        total++; if (n_both !== 0) begin bad++; $display("FAIL strobes_overlap got=%0d want=0", n_both); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
